// File: rtl/tetris_piece_engine.sv
// Purpose: falling-piece controller for a block-stacking game; checks moves against an external board RAM and locks pieces into it.
// Latency: a move accepted in FALL at cycle t updates piece_x/piece_y/rot at t+6; a lock takes 4 write cycles, then lock_done.
// Backpressure: none; move pulses outside FALL are dropped, except one gravity tick which is held until the next FALL cycle.
// Ports: CLOCK_50/resetn clock and sync active-low reset; left/right/rot_final, tick_gravity move pulses; next_shape spawn shape;
//        board_rx/ry + board_rdata board read (1-cycle latency); board_we/wx/wy/wdata board write;
//        piece_x/piece_y/rot/shape_id active piece; lock_done pulse after lock writes; game_over sticky.
module tetris_piece_engine #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int XW      = 4,
    parameter int YW      = 5
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 left_final,
    input  logic                 right_final,
    input  logic                 rot_final,
    input  logic                 tick_gravity,
    input  logic [2:0]           next_shape,
    output logic [XW-1:0]        board_rx,
    output logic [YW-1:0]        board_ry,
    input  logic                 board_rdata,
    output logic                 board_we,
    output logic [XW-1:0]        board_wx,
    output logic [YW-1:0]        board_wy,
    output logic                 board_wdata,
    output logic signed [XW:0]   piece_x,
    output logic [YW-1:0]        piece_y,
    output logic [1:0]           rot,
    output logic [2:0]           shape_id,
    output logic                 lock_done,
    output logic                 game_over
);

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_FALL, S_CHECK, S_EVAL, S_LOCK, S_GAMEOVER
    } state_t;

    localparam logic [XW:0]   BW      = (XW+1)'(BOARD_W);
    localparam logic [YW:0]   BH      = (YW+1)'(BOARD_H);
    localparam logic [XW-1:0] XMAX    = XW'(BOARD_W - 1);
    localparam logic [YW-1:0] YMAX    = YW'(BOARD_H - 1);
    localparam logic [XW:0]   SPAWN_X = (XW+1)'((BOARD_W - 4) / 2);

    // Cell table: one nibble {dx,dy} per cell, cell 0 in the top nibble;
    // per shape the four rotations are packed rot0 (MSB) .. rot3 (LSB).
    function automatic logic [15:0] shape_cells(input logic [2:0] s, input logic [1:0] r);
        logic [63:0] row;
        case (s)
            3'd1:    row = 64'h4859_4859_4859_4859; // O
            3'd2:    row = 64'h4159_4596_1596_4156; // T
            3'd3:    row = 64'h4815_459A_5926_0156; // S
            3'd4:    row = 64'h0459_8596_156A_4152; // Z
            3'd5:    row = 64'h0159_4856_159A_4526; // J
            3'd6:    row = 64'h8159_456A_1592_0456; // L
            default: row = 64'h159D_89AB_26AE_4567; // I
        endcase
        return row[{~r, 4'b0000} +: 16];
    endfunction

    state_t               r_state, w_next;
    logic [1:0]           r_cnt;
    logic signed [XW:0]   r_piece_x;
    logic [YW-1:0]        r_piece_y;
    logic [1:0]           r_rot, r_new_rot;
    logic [2:0]           r_shape;
    logic signed [1:0]    r_mdx;
    logic                 r_mdy;
    logic                 r_is_grav, r_is_spawn;
    logic                 r_collide, r_rd_vld, r_grav_pend;
    logic                 r_lock_done, r_game_over;

    logic                 w_grav_req, w_hit, w_col;
    logic [1:0]           w_calc_rot;
    logic signed [1:0]    w_mdx;
    logic                 w_mdy;
    logic [15:0]          w_cells;
    logic [3:0]           w_nib;
    logic signed [XW+1:0] w_tx;
    logic [YW:0]          w_ty;
    logic                 w_tx_neg, w_tx_hi, w_ty_hi, w_oob;

    assign w_grav_req = tick_gravity | r_grav_pend;
    // A read issued last cycle for an in-range cell returns its occupancy now.
    assign w_hit      = r_rd_vld & board_rdata;
    assign w_col      = r_collide | w_hit;

    // One shared cell-address datapath: CHECK uses the candidate move,
    // LOCK uses the current placement.
    assign w_calc_rot = (r_state == S_CHECK) ? r_new_rot : r_rot;
    assign w_mdx      = (r_state == S_CHECK) ? r_mdx : 2'sb00;
    assign w_mdy      = (r_state == S_CHECK) ? r_mdy : 1'b0;
    assign w_cells    = shape_cells(r_shape, w_calc_rot);
    assign w_nib      = w_cells[{~r_cnt, 2'b00} +: 4];
    assign w_tx       = {r_piece_x[XW], r_piece_x} + {{XW{w_mdx[1]}}, w_mdx} + {{XW{1'b0}}, w_nib[3:2]};
    assign w_ty       = {1'b0, r_piece_y} + {{YW{1'b0}}, w_mdy} + {{(YW-1){1'b0}}, w_nib[1:0]};
    assign w_tx_neg   = w_tx[XW+1];
    assign w_tx_hi    = !w_tx_neg && (w_tx[XW:0] >= BW);
    assign w_ty_hi    = (w_ty >= BH);
    assign w_oob      = w_tx_neg | w_tx_hi | w_ty_hi;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        board_rx    = '0;
        board_ry    = '0;
        board_we    = 1'b0;
        board_wx    = '0;
        board_wy    = '0;
        board_wdata = 1'b0;
        case (r_state)
            S_IDLE:  w_next = S_SPAWN;
            S_SPAWN: w_next = S_CHECK;
            S_FALL:  if (w_grav_req | rot_final | left_final | right_final) w_next = S_CHECK;
            S_CHECK: begin
                // Off-board targets still present a clamped, legal address.
                board_rx = w_tx_neg ? '0 : (w_tx_hi ? XMAX : w_tx[XW-1:0]);
                board_ry = w_ty_hi ? YMAX : w_ty[YW-1:0];
                if (r_cnt == 2'd3) w_next = S_EVAL;
            end
            S_EVAL: begin
                if (r_is_spawn)            w_next = w_col ? S_GAMEOVER : S_FALL;
                else if (w_col && r_is_grav) w_next = S_LOCK;
                else                       w_next = S_FALL;
            end
            S_LOCK: begin
                board_we    = 1'b1;
                board_wdata = 1'b1;
                board_wx    = w_tx[XW-1:0];
                board_wy    = w_ty[YW-1:0];
                if (r_cnt == 2'd3) w_next = S_SPAWN;
            end
            S_GAMEOVER: w_next = S_GAMEOVER;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_cnt <= '0; r_piece_x <= '0; r_piece_y <= '0; r_rot <= '0; r_new_rot <= '0;
            r_shape <= '0; r_mdx <= '0; r_mdy <= 1'b0; r_is_grav <= 1'b0; r_is_spawn <= 1'b0;
            r_collide <= 1'b0; r_rd_vld <= 1'b0; r_grav_pend <= 1'b0;
            r_lock_done <= 1'b0; r_game_over <= 1'b0;
        end else begin
            r_cnt       <= (r_state == S_CHECK || r_state == S_LOCK) ? r_cnt + 2'd1 : 2'd0;
            r_rd_vld    <= (r_state == S_CHECK) && !w_oob;
            r_lock_done <= (r_state == S_LOCK) && (r_cnt == 2'd3);
            // Gravity is always the selected request in FALL, so the pending flag is consumed there.
            r_grav_pend <= (r_state == S_FALL) ? 1'b0 : (r_grav_pend | tick_gravity);
            case (r_state)
                S_SPAWN: begin
                    r_shape    <= (next_shape == 3'd7) ? 3'd0 : next_shape;
                    r_rot      <= 2'd0;
                    r_piece_x  <= SPAWN_X;
                    r_piece_y  <= '0;
                    r_mdx      <= 2'sb00;
                    r_mdy      <= 1'b0;
                    r_new_rot  <= 2'd0;
                    r_is_spawn <= 1'b1;
                    r_is_grav  <= 1'b0;
                    r_collide  <= 1'b0;
                end
                S_FALL: begin
                    r_mdx      <= 2'sb00;
                    r_mdy      <= 1'b0;
                    r_new_rot  <= r_rot;
                    r_is_grav  <= 1'b0;
                    r_is_spawn <= 1'b0;
                    r_collide  <= 1'b0;
                    if (w_grav_req) begin
                        r_mdy     <= 1'b1;
                        r_is_grav <= 1'b1;
                    end else if (rot_final) begin
                        r_new_rot <= r_rot + 2'd1;
                    end else if (left_final) begin
                        r_mdx <= -2'sd1;
                    end else if (right_final) begin
                        r_mdx <= 2'sd1;
                    end
                end
                S_CHECK: r_collide <= r_collide | w_oob | w_hit;
                S_EVAL: begin
                    if (!w_col) begin
                        r_piece_x <= r_piece_x + {{(XW-1){r_mdx[1]}}, r_mdx};
                        r_piece_y <= r_piece_y + {{(YW-1){1'b0}}, r_mdy};
                        r_rot     <= r_new_rot;
                    end
                    if (r_is_spawn && w_col) r_game_over <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign piece_x   = r_piece_x;
    assign piece_y   = r_piece_y;
    assign rot       = r_rot;
    assign shape_id  = r_shape;
    assign lock_done = r_lock_done;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_tetris_piece_engine.sv
module tb_tetris_piece_engine;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              left_final = 1'b0, right_final = 1'b0, rot_final = 1'b0, tick_gravity = 1'b0;
    logic [2:0]        next_shape = 3'd1;
    logic [3:0]        board_rx, board_wx;
    logic [4:0]        board_ry, board_wy;
    logic              board_rdata = 1'b0;
    logic              board_we, board_wdata;
    logic signed [4:0] piece_x;
    logic [4:0]        piece_y;
    logic [1:0]        rot;
    logic [2:0]        shape_id;
    logic              lock_done, game_over;

    tetris_piece_engine dut (
        .CLOCK_50(clk), .resetn(resetn),
        .left_final(left_final), .right_final(right_final), .rot_final(rot_final),
        .tick_gravity(tick_gravity), .next_shape(next_shape),
        .board_rx(board_rx), .board_ry(board_ry), .board_rdata(board_rdata),
        .board_we(board_we), .board_wx(board_wx), .board_wy(board_wy), .board_wdata(board_wdata),
        .piece_x(piece_x), .piece_y(piece_y), .rot(rot), .shape_id(shape_id),
        .lock_done(lock_done), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int r; } pos_t;
    typedef struct { int x; int y; } cell_t;

    pos_t   exp_q[$];
    cell_t  wr_q[$];
    int     n_cmp = 0, n_err = 0, n_we = 0, n_lock = 0;
    logic   prev_we = 1'b0;
    int     tb_cmd = 0;
    bit [9:0] board [20];

    // Board RAM model: 1-cycle read latency, plus preload commands.
    always @(posedge clk) begin
        if (tb_cmd != 0) begin
            for (int y = 0; y < 20; y++) board[y] <= '0;
            if (tb_cmd == 2) begin
                for (int x = 3; x <= 6; x++) begin
                    board[0][x] <= 1'b1;
                    board[1][x] <= 1'b1;
                end
            end else if (tb_cmd == 3) begin
                board[2][4] <= 1'b1;
                board[2][5] <= 1'b1;
            end
        end else if (board_we) begin
            board[board_wy][board_wx] <= 1'b1;
        end
        board_rdata <= (board_ry < 5'd20 && board_rx < 4'd10) ? board[board_ry][board_rx] : 1'b0;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // m: bit0 gravity, bit1 rotate, bit2 left, bit3 right; held for one sampling edge.
    task automatic drive(input int m);
        @(negedge clk);
        tick_gravity = m[0]; rot_final = m[1]; left_final = m[2]; right_final = m[3];
        @(negedge clk);
        tick_gravity = 1'b0; rot_final = 1'b0; left_final = 1'b0; right_final = 1'b0;
    endtask

    function automatic int pack_pos();
        return (int'(piece_x) * 64 + int'(piece_y)) * 4 + int'(rot);
    endfunction

    task automatic do_move(input int m, input int ex, input int ey, input int er, input string tag);
        int   old;
        pos_t p;
        old = pack_pos();
        exp_q.push_back('{ex, ey, er});
        drive(m);
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_hold"}, pack_pos(), old);
        @(posedge clk);
        #1;
        p = exp_q.pop_front();
        check_eq({tag, "_x"}, int'(piece_x), p.x);
        check_eq({tag, "_y"}, int'(piece_y), p.y);
        check_eq({tag, "_rot"}, int'(rot), p.r);
    endtask

    task automatic reset_with(input int cmd, input int shape);
        @(negedge clk);
        resetn = 1'b0; tb_cmd = cmd; next_shape = shape[2:0];
        @(negedge clk);
        tb_cmd = 0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        pos_t p;
        int   nwe0;

        fork
            forever begin
                @(negedge clk);
                if (board_we) begin
                    cell_t c;
                    n_we++;
                    check_eq("wr_expected", int'(wr_q.size() > 0), 1);
                    if (wr_q.size() > 0) begin
                        c = wr_q.pop_front();
                        check_eq("wr_x", int'(board_wx), c.x);
                        check_eq("wr_y", int'(board_wy), c.y);
                        check_eq("wr_data", int'(board_wdata), 1);
                    end
                end
                if (lock_done) begin
                    n_lock++;
                    check_eq("lock_after_wr", int'(prev_we), 1);
                    check_eq("lock_q_empty", wr_q.size(), 0);
                end
                prev_we = board_we;
            end
            begin
                #200000;
                $display("FAIL watchdog: run did not finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state (board cleared via preload command)
        tb_cmd = 1;
        repeat (2) @(negedge clk);
        tb_cmd = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_we", int'(board_we), 0);
        check_eq("rst_lock_done", int'(lock_done), 0);
        check_eq("rst_game_over", int'(game_over), 0);
        check_eq("rst_piece_x", int'(piece_x), 0);
        check_eq("rst_piece_y", int'(piece_y), 0);
        check_eq("rst_rot", int'(rot), 0);
        check_eq("rst_shape", int'(shape_id), 0);
        check_eq("rst_rx", int'(board_rx), 0);

        // O piece spawn, gravity latency, same-cycle priority, rotate, walls
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("spawn_x", int'(piece_x), 3);
        check_eq("spawn_y", int'(piece_y), 0);
        check_eq("spawn_rot", int'(rot), 0);
        check_eq("spawn_shape", int'(shape_id), 1);
        do_move(1, 3, 1, 0, "grav1");
        do_move(1 | 4, 3, 2, 0, "grav_left");
        do_move(2, 3, 2, 1, "rot_o");
        do_move(4, 2, 2, 1, "left_o");
        do_move(8, 3, 2, 1, "right_o");
        for (int i = 3; i <= 18; i++) do_move(1, 3, i, 1, "drop");

        // 19th tick locks the O piece at the floor
        next_shape = 3'd0;
        wr_q.push_back('{4, 18});
        wr_q.push_back('{5, 18});
        wr_q.push_back('{4, 19});
        wr_q.push_back('{5, 19});
        drive(1);
        repeat (20) @(negedge clk);
        check_eq("lock_count", n_lock, 1);
        check_eq("lock_writes_left", wr_q.size(), 0);
        check_eq("respawn_shape", int'(shape_id), 0);
        check_eq("respawn_x", int'(piece_x), 3);
        check_eq("respawn_y", int'(piece_y), 0);
        check_eq("respawn_go", int'(game_over), 0);

        // I piece against the right wall
        do_move(8, 4, 0, 0, "i_r1");
        do_move(8, 5, 0, 0, "i_r2");
        do_move(8, 6, 0, 0, "i_r3");
        do_move(8, 6, 0, 0, "i_wall");
        do_move(4, 5, 0, 0, "i_left");
        do_move(2, 5, 0, 1, "i_rot");

        // Gravity during CHECK is held; a left pulse in the same cycle is dropped
        exp_q.push_back('{6, 0, 1});
        exp_q.push_back('{6, 1, 1});
        drive(8);
        @(negedge clk);
        tick_gravity = 1'b1; left_final = 1'b1;
        @(negedge clk);
        tick_gravity = 1'b0; left_final = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        p = exp_q.pop_front();
        check_eq("pend_right_x", int'(piece_x), p.x);
        check_eq("pend_right_y", int'(piece_y), p.y);
        repeat (6) @(posedge clk);
        #1;
        p = exp_q.pop_front();
        check_eq("pend_grav_x", int'(piece_x), p.x);
        check_eq("pend_grav_y", int'(piece_y), p.y);
        check_eq("pend_grav_rot", int'(rot), p.r);

        // Reset in the middle of a lock: shape 7 spawns as I, lands on (4,2)
        reset_with(3, 7);
        check_eq("s7_shape", int'(shape_id), 0);
        check_eq("s7_x", int'(piece_x), 3);
        wr_q.push_back('{3, 1});
        wr_q.push_back('{4, 1});
        drive(1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_we", int'(board_we), 0);
        check_eq("mid_rst_x", int'(piece_x), 0);
        check_eq("mid_rst_y", int'(piece_y), 0);
        check_eq("mid_rst_lock_done", int'(lock_done), 0);
        check_eq("mid_rst_wx", int'(board_wx), 0);
        repeat (3) @(negedge clk);
        check_eq("mid_rst_cell2", int'(board[1][4]), 1);
        check_eq("mid_rst_cell3", int'(board[1][5]), 0);
        check_eq("mid_rst_q", wr_q.size(), 0);

        // Spawn collision: game over, no writes, sticky
        reset_with(2, 3);
        nwe0 = n_we;
        check_eq("go_set", int'(game_over), 1);
        drive(1);
        drive(4);
        repeat (20) @(negedge clk);
        check_eq("go_sticky", int'(game_over), 1);
        check_eq("go_no_writes", n_we - nwe0, 0);
        check_eq("go_we", int'(board_we), 0);
        check_eq("go_lock_count", n_lock, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
